// File: rtl/bp_cfg_loader_if.sv
// Config-link bundle between the boot sequencer (master) and the per-tile config network (slave).
interface bp_cfg_loader_if #(
    parameter int unsigned core_width_p     = 2,
    parameter int unsigned cfg_addr_width_p = 16,
    parameter int unsigned cfg_data_width_p = 32
) ();
    logic                        cfg_v_o;
    logic                        cfg_ready_i;
    logic [core_width_p-1:0]     cfg_core_o;
    logic [cfg_addr_width_p-1:0] cfg_addr_o;
    logic [cfg_data_width_p-1:0] cfg_data_o;
    logic                        cfg_ack_i;

    modport master (
        output cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o,
        input  cfg_ready_i, cfg_ack_i
    );

    modport slave (
        input  cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o,
        output cfg_ready_i, cfg_ack_i
    );
endinterface

// File: rtl/bp_cfg_loader.sv
// Post-reset boot sequencer: freeze, core ID, boot PC per core, then unfreeze every core.
// Optional ack watchdog enabled by defining BP_CFG_LOADER_TIMEOUT_EN.
module bp_cfg_loader #(
    parameter int unsigned num_core_p        = 4,
    parameter int unsigned cfg_addr_width_p  = 16,
    parameter int unsigned cfg_data_width_p  = 32,
    parameter logic [31:0] boot_pc_p         = 32'h8000_0000,
    parameter int unsigned max_outstanding_p = 2,
    parameter int unsigned timeout_cycles_p  = 1024
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    bp_cfg_loader_if.master    cfg_if,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o
);
    localparam int unsigned core_width_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int unsigned outst_width_lp = $clog2(max_outstanding_p + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FREEZE, S_CORE_ID, S_NPC, S_UNFREEZE, S_DRAIN, S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [core_width_lp-1:0]    core_q, core_d;
    logic [outst_width_lp-1:0]   outst_q, outst_d;
    logic                        error_q, error_d;
    logic                        done_q, done_d;
    logic [core_width_lp-1:0]    cfg_core_q, cfg_core_d;
    logic [cfg_addr_width_p-1:0] cfg_addr_q, cfg_addr_d;
    logic [cfg_data_width_p-1:0] cfg_data_q, cfg_data_d;

    logic write_phase, cfg_v, hs, ack, last_core;

    assign write_phase = (state_q == S_FREEZE) || (state_q == S_CORE_ID) ||
                         (state_q == S_NPC)    || (state_q == S_UNFREEZE);
    assign cfg_v       = write_phase && (outst_q < outst_width_lp'(max_outstanding_p));
    assign hs          = cfg_v && cfg_if.cfg_ready_i;
    assign ack         = cfg_if.cfg_ack_i;
    assign last_core   = (core_q == core_width_lp'(num_core_p - 1));

`ifdef BP_CFG_LOADER_TIMEOUT_EN
    localparam int unsigned wd_width_lp = $clog2(timeout_cycles_p + 1);
    logic [wd_width_lp-1:0] wd_q, wd_d;
    logic                   timeout;

    always_comb begin
        wd_d    = '0;
        timeout = 1'b0;
        if (!ack && (outst_q != '0)) begin
            wd_d    = wd_q + wd_width_lp'(1);
            timeout = (wd_q == wd_width_lp'(timeout_cycles_p - 1));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) wd_q <= '0;
        else            wd_q <= wd_d;
    end
`else
    logic [31:0] unused_timeout;
    logic        timeout;
    assign unused_timeout = 32'(timeout_cycles_p);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        core_d  = core_q;
        outst_d = outst_q;
        error_d = error_q;
        done_d  = done_q;

        unique case (state_q)
            S_IDLE: if (start_i) begin
                state_d = S_FREEZE;
                core_d  = '0;
            end
            S_FREEZE:  if (hs) state_d = S_CORE_ID;
            S_CORE_ID: if (hs) state_d = S_NPC;
            S_NPC: if (hs) begin
                if (last_core) begin
                    state_d = S_UNFREEZE;
                    core_d  = '0;
                end else begin
                    state_d = S_FREEZE;
                    core_d  = core_q + core_width_lp'(1);
                end
            end
            S_UNFREEZE: if (hs) begin
                if (last_core) state_d = S_DRAIN;
                else           core_d  = core_q + core_width_lp'(1);
            end
            S_DRAIN: if (outst_q == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // An ack with nothing outstanding is flagged but never underflows the count.
        if (hs && !ack) begin
            outst_d = outst_q + outst_width_lp'(1);
        end else if (ack && !hs) begin
            if (outst_q == '0) error_d = 1'b1;
            else               outst_d = outst_q - outst_width_lp'(1);
        end

        if (timeout) begin
            error_d = 1'b1;
            outst_d = '0;
            state_d = S_DONE;
            done_d  = 1'b0;
        end
    end

    // Write fields are decoded from the next state so they are flop outputs and hold during stalls.
    always_comb begin
        cfg_core_d = '0;
        cfg_addr_d = '0;
        cfg_data_d = '0;
        unique case (state_d)
            S_FREEZE: begin
                cfg_core_d = core_d;
                cfg_addr_d = cfg_addr_width_p'(1);
                cfg_data_d = cfg_data_width_p'(1);
            end
            S_CORE_ID: begin
                cfg_core_d = core_d;
                cfg_addr_d = cfg_addr_width_p'(2);
                cfg_data_d = cfg_data_width_p'(core_d);
            end
            S_NPC: begin
                cfg_core_d = core_d;
                cfg_addr_d = cfg_addr_width_p'(3);
                cfg_data_d = cfg_data_width_p'(boot_pc_p);
            end
            S_UNFREEZE: begin
                cfg_core_d = core_d;
                cfg_addr_d = cfg_addr_width_p'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            core_q     <= '0;
            outst_q    <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
            cfg_core_q <= '0;
            cfg_addr_q <= '0;
            cfg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            core_q     <= core_d;
            outst_q    <= outst_d;
            error_q    <= error_d;
            done_q     <= done_d;
            cfg_core_q <= cfg_core_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
        end
    end

    assign cfg_if.cfg_v_o    = cfg_v;
    assign cfg_if.cfg_core_o = cfg_core_q;
    assign cfg_if.cfg_addr_o = cfg_addr_q;
    assign cfg_if.cfg_data_o = cfg_data_q;
    assign busy_o            = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o            = done_q;
    assign error_o           = error_q;
endmodule

// File: tb/tb_bp_cfg_loader.sv
// Self-checking bench for bp_cfg_loader: 1-core vector table plus a 4-core queue-based reference model.
module tb_bp_cfg_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b1;
    logic start, busy, done, err;
    logic start1, busy1, done1, err1;

    bp_cfg_loader_if #(.core_width_p(2), .cfg_addr_width_p(16), .cfg_data_width_p(32)) cif ();
    bp_cfg_loader_if #(.core_width_p(1), .cfg_addr_width_p(16), .cfg_data_width_p(32)) cif1 ();

    bp_cfg_loader #(.num_core_p(4), .max_outstanding_p(2), .timeout_cycles_p(16)) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .cfg_if(cif),
        .busy_o(busy), .done_o(done), .error_o(err));

    bp_cfg_loader #(.num_core_p(1), .max_outstanding_p(2)) dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start1), .cfg_if(cif1),
        .busy_o(busy1), .done_o(done1), .error_o(err1));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the expected write list plus plain bookkeeping flags.
    typedef struct { logic [1:0] core; logic [15:0] addr; logic [31:0] data; } wr_t;
    wr_t exp_q[$];
    bit  m_started, m_drain, m_done, m_err;
    int  m_outst;

    task automatic model_reset();
        exp_q.delete();
        m_started = 0; m_drain = 0; m_done = 0; m_err = 0; m_outst = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 0; cif.cfg_ready_i = 0; cif.cfg_ack_i = 0;
        start1 = 0; cif1.cfg_ready_i = 0; cif1.cfg_ack_i = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic s, input logic r, input logic a, output bit hs);
        bit exp_v;
        @(negedge clk);
        exp_v = m_started && !m_done && !m_drain && (exp_q.size() > 0) && (m_outst < 2);
        chk("cfg_v", cif.cfg_v_o, exp_v);
        chk("busy", busy, m_started && !m_done);
        chk("done", done, m_done);
        chk("error", err, m_err);
        if (exp_v) begin
            chk("core", cif.cfg_core_o, exp_q[0].core);
            chk("addr", cif.cfg_addr_o, exp_q[0].addr);
            chk("data", cif.cfg_data_o, exp_q[0].data);
        end
        start = s; cif.cfg_ready_i = r; cif.cfg_ack_i = a;
        hs = cif.cfg_v_o && r;
        if (!m_started) begin
            if (s) begin
                m_started = 1;
                for (int c = 0; c < 4; c++) begin
                    exp_q.push_back('{c[1:0], 16'h1, 32'h1});
                    exp_q.push_back('{c[1:0], 16'h2, 32'(c)});
                    exp_q.push_back('{c[1:0], 16'h3, 32'h8000_0000});
                end
                for (int c = 0; c < 4; c++) exp_q.push_back('{c[1:0], 16'h1, 32'h0});
            end
        end else if (m_drain) begin
            if (m_outst == 0) begin m_drain = 0; m_done = 1; end
        end else if (!m_done && exp_v && r) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_drain = 1;
        end
        if (exp_v && r && !a) m_outst++;
        else if (a && !(exp_v && r)) begin
            if (m_outst == 0) m_err = 1;
            else              m_outst--;
        end
    endtask

    task automatic run_to_done(input int maxcyc);
        bit hs;
        int cyc = 0;
        while (!m_done && cyc < maxcyc) begin
            step(0, $urandom_range(0, 9) < 7, (m_outst > 0) && ($urandom_range(0, 1) == 1), hs);
            cyc++;
        end
        step(0, 0, 0, hs);
        chk("run_done", done, 1);
    endtask

    typedef struct {
        logic s, r, a;
        logic v; logic [15:0] addr; logic [31:0] data;
        logic busy, done, err;
    } vec_t;
    vec_t tbl[11];

    initial begin
        bit hs;
        int n;
        logic [1:0]  cap_core;
        logic [15:0] cap_addr;
        logic [31:0] cap_data;

        tbl[0]  = '{1, 1, 0, 0, 16'h0, 32'h0,          0, 0, 0};
        tbl[1]  = '{0, 1, 0, 1, 16'h1, 32'h1,          1, 0, 0};
        tbl[2]  = '{0, 1, 1, 1, 16'h2, 32'h0,          1, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 16'h3, 32'h8000_0000,  1, 0, 0};
        tbl[4]  = '{0, 1, 1, 1, 16'h1, 32'h0,          1, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 16'h0, 32'h0,          1, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 16'h0, 32'h0,          1, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 16'h0, 32'h0,          0, 1, 0};
        tbl[8]  = '{0, 1, 1, 0, 16'h0, 32'h0,          0, 1, 0};
        tbl[9]  = '{0, 0, 0, 0, 16'h0, 32'h0,          0, 1, 1};
        tbl[10] = '{0, 0, 0, 0, 16'h0, 32'h0,          0, 1, 1};

        do_reset();

        // Single-core sequence with an ack one cycle after every handshake.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_v", i), cif1.cfg_v_o, tbl[i].v);
            chk($sformatf("tbl%0d_busy", i), busy1, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), done1, tbl[i].done);
            chk($sformatf("tbl%0d_err", i), err1, tbl[i].err);
            if (tbl[i].v) begin
                chk($sformatf("tbl%0d_core", i), cif1.cfg_core_o, 0);
                chk($sformatf("tbl%0d_addr", i), cif1.cfg_addr_o, tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), cif1.cfg_data_o, tbl[i].data);
            end
            start1 = tbl[i].s; cif1.cfg_ready_i = tbl[i].r; cif1.cfg_ack_i = tbl[i].a;
        end

        // Spurious ack before start.
        do_reset();
        step(0, 0, 1, hs);
        step(0, 0, 0, hs);
        chk("spurious_err", err, 1);

        // Acks withheld: window of two, then one ack frees exactly one slot.
        do_reset();
        step(1, 1, 0, hs);
        n = 0;
        repeat (6) begin step(0, 1, 0, hs); n += int'(hs); end
        chk("withheld_hs", n, 2);
        chk("withheld_v", cif.cfg_v_o, 0);
        step(0, 1, 1, hs);
        n = 0;
        repeat (5) begin step(0, 1, 0, hs); n += int'(hs); end
        chk("one_more_hs", n, 1);
        step(0, 1, 1, hs);
        step(0, 1, 1, hs);
        chk("same_cycle_hs", hs, 1);
        n = 0;
        repeat (4) begin step(0, 1, 0, hs); n += int'(hs); end
        chk("count_held", n, 1);

        // Ready held low for 5 cycles while the boot-PC write is presented.
        do_reset();
        step(1, 1, 0, hs);
        n = 0;
        while (!(exp_q.size() > 0 && exp_q[0].addr == 16'h3 && m_outst < 2) && n < 50) begin
            step(0, 1, m_outst > 0, hs);
            n++;
        end
        step(0, 0, m_outst > 0, hs);
        cap_core = cif.cfg_core_o; cap_addr = cif.cfg_addr_o; cap_data = cif.cfg_data_o;
        chk("stall_addr_npc", cap_addr, 16'h3);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, m_outst > 0, hs);
            chk("stall_v", cif.cfg_v_o, 1);
            chk("stall_core", cif.cfg_core_o, cap_core);
            chk("stall_addr", cif.cfg_addr_o, cap_addr);
            chk("stall_data", cif.cfg_data_o, cap_data);
        end
        step(0, 1, 0, hs);
        chk("release_hs", hs, 1);
        step(0, 0, m_outst > 0, hs);
        chk("post_release_addr", cif.cfg_addr_o, 16'h1);
        run_to_done(400);

        // Reset after the 6th handshake, then a full restart from core 0.
        do_reset();
        step(1, 1, 0, hs);
        n = 0;
        for (int k = 0; k < 50 && n < 6; k++) begin
            step(0, 1, m_outst > 0, hs);
            n += int'(hs);
        end
        chk("pre_reset_hs", n, 6);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_v", cif.cfg_v_o, 0);
        chk("rst_core", cif.cfg_core_o, 0);
        chk("rst_addr", cif.cfg_addr_o, 0);
        chk("rst_data", cif.cfg_data_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        start = 0; cif.cfg_ready_i = 0; cif.cfg_ack_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(0, 0, 1, hs);
        step(1, 1, 0, hs);
        chk("late_ack_err", err, 1);
        run_to_done(400);

        // Fully randomized run.
        do_reset();
        step(1, 1, 0, hs);
        run_to_done(600);

`ifdef BP_CFG_LOADER_TIMEOUT_EN
        // Final ack dropped: watchdog ends the sequence without done.
        do_reset();
        step(1, 1, 0, hs);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step(0, 1, m_outst > 0, hs);
            n++;
        end
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            cif.cfg_ack_i = 0; cif.cfg_ready_i = 0;
            if (!busy) begin n = k; break; end
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_err", err, 1);
        chk("timeout_done", done, 0);
        repeat (3) @(negedge clk);
        chk("timeout_terminal", busy, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
